// File: rtl/sic_reg_client_pkg.sv
// Shared types and constants for the SIC register-file client.
package sic_pkg;

   // Client sequencing: acquire locks, execute, release locks.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      EXEC = 2'd2,
      REL  = 2'd3
   } sic_state_e;

   // Ports owned by one SIC instance, in global port order.
   localparam int NUM_PORTS  = 3;
   localparam int PORT_RS    = 0;
   localparam int PORT_RT    = 1;
   localparam int PORT_RD    = 2;
   localparam int DATA_WIDTH = 32;

   // True when a register address names an existing physical register.
   function automatic logic addr_in_range(input int unsigned addr,
                                          input int unsigned num_regs);
      return (addr < num_regs);
   endfunction

endpackage

// File: rtl/sic_reg_client_if.sv
// Bus bundles for the register-file client: the issue/execute side and the
// three register-file ports owned by the client.

// Issue/execute side. The client is the slave; the issuer/execute unit is the master.
interface sic_op_if import sic_pkg::*; #(
   parameter int NUM_PHY_REGS = 32,
   parameter int ID_WIDTH     = 8
);
   localparam int AW = (NUM_PHY_REGS > 1) ? $clog2(NUM_PHY_REGS) : 1;

   logic                  op_valid;
   logic                  op_ready;
   logic [ID_WIDTH-1:0]   op_issue_id;
   logic                  op_rs_en;
   logic                  op_rt_en;
   logic                  op_rd_en;
   logic [AW-1:0]         op_rs_addr;
   logic [AW-1:0]         op_rt_addr;
   logic [AW-1:0]         op_rd_addr;
   logic                  src_valid;
   logic [DATA_WIDTH-1:0] src_rs_data;
   logic [DATA_WIDTH-1:0] src_rt_data;
   logic                  ex_done;
   logic [DATA_WIDTH-1:0] ex_wdata;
   logic                  op_done;

   modport master (
      output op_valid, op_issue_id, op_rs_en, op_rt_en, op_rd_en,
             op_rs_addr, op_rt_addr, op_rd_addr, ex_done, ex_wdata,
      input  op_ready, src_valid, src_rs_data, src_rt_data, op_done
   );

   modport slave (
      input  op_valid, op_issue_id, op_rs_en, op_rt_en, op_rd_en,
             op_rs_addr, op_rt_addr, op_rd_addr, ex_done, ex_wdata,
      output op_ready, src_valid, src_rs_data, src_rt_data, op_done
   );
endinterface

// Register-file side. The client is the master; the register file is the slave.
interface sic_port_if import sic_pkg::*; #(
   parameter int NUM_PHY_REGS = 32,
   parameter int ID_WIDTH     = 8
);
   localparam int AW = (NUM_PHY_REGS > 1) ? $clog2(NUM_PHY_REGS) : 1;

   logic [NUM_PORTS-1:0][AW-1:0]         port_addr;
   logic [NUM_PORTS-1:0]                 port_req_read;
   logic [NUM_PORTS-1:0]                 port_req_write;
   logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   port_issue_id;
   logic [NUM_PORTS-1:0]                 port_release;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_rdata;
   logic [NUM_PORTS-1:0]                 port_grant;

   modport master (
      output port_addr, port_req_read, port_req_write, port_issue_id,
             port_release, port_wdata,
      input  port_rdata, port_grant
   );

   modport slave (
      input  port_addr, port_req_read, port_req_write, port_issue_id,
             port_release, port_wdata,
      output port_rdata, port_grant
   );
endinterface

// File: rtl/sic_reg_client.sv
// Per-instruction requester for the locking register file. Acquires the
// rs/rt read locks and the rd write lock for one operation, hands the read
// operands to execute, then releases every held lock (committing the write).
// All outputs are registered: each output register is loaded from the value
// the output must have in the next state, so outputs line up with the state.
module sic_reg_client import sic_pkg::*; #(
   parameter int NUM_PHY_REGS = 32,
   parameter int ID_WIDTH     = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sic_op_if.slave              op_bus,
   sic_port_if.master           port_bus,
   output logic [CNT_WIDTH-1:0] acq_stall_cnt
);

   localparam int AW = (NUM_PHY_REGS > 1) ? $clog2(NUM_PHY_REGS) : 1;

   // Sequencer state and per-operation latches.
   sic_state_e                            state_r, state_s;
   logic [ID_WIDTH-1:0]                   id_r, id_s;
   logic [NUM_PORTS-1:0][AW-1:0]          addr_r, addr_s;
   logic [NUM_PORTS-1:0]                  en_r, en_s;
   logic [NUM_PORTS-1:0]                  g_r, g_s;
   logic [1:0][DATA_WIDTH-1:0]            rdata_r, rdata_s;
   logic [DATA_WIDTH-1:0]                 wb_r, wb_s;
   logic [NUM_PORTS-1:0]                  en_mask_s;

   // Output registers and their next values.
   logic                                  op_ready_r, op_ready_s;
   logic                                  src_valid_r, src_valid_s;
   logic [DATA_WIDTH-1:0]                 src_rs_r, src_rs_s;
   logic [DATA_WIDTH-1:0]                 src_rt_r, src_rt_s;
   logic                                  op_done_r, op_done_s;
   logic [NUM_PORTS-1:0][AW-1:0]          paddr_r, paddr_s;
   logic [NUM_PORTS-1:0]                  req_rd_r, req_rd_s;
   logic [NUM_PORTS-1:0]                  req_wr_r, req_wr_s;
   logic [NUM_PORTS-1:0][ID_WIDTH-1:0]    pid_r, pid_s;
   logic [NUM_PORTS-1:0]                  rel_r, rel_s;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  pwdata_r, pwdata_s;
   logic [CNT_WIDTH-1:0]                  cnt_r, cnt_s;
   logic                                  held_s;

   // Port enables after dropping addresses that name no physical register.
   always_comb begin
      en_mask_s          = '0;
      en_mask_s[PORT_RS] = op_bus.op_rs_en &&
                           addr_in_range(32'(op_bus.op_rs_addr), 32'(NUM_PHY_REGS));
      en_mask_s[PORT_RT] = op_bus.op_rt_en &&
                           addr_in_range(32'(op_bus.op_rt_addr), 32'(NUM_PHY_REGS));
      en_mask_s[PORT_RD] = op_bus.op_rd_en &&
                           addr_in_range(32'(op_bus.op_rd_addr), 32'(NUM_PHY_REGS));
   end

   // Next state and next values of the operation latches.
   always_comb begin
      state_s = state_r;
      id_s    = id_r;
      addr_s  = addr_r;
      en_s    = en_r;
      g_s     = g_r;
      rdata_s = rdata_r;
      wb_s    = wb_r;
      case (state_r)
         IDLE: begin
            if (op_bus.op_valid && op_ready_r) begin
               id_s             = op_bus.op_issue_id;
               addr_s[PORT_RS]  = op_bus.op_rs_addr;
               addr_s[PORT_RT]  = op_bus.op_rt_addr;
               addr_s[PORT_RD]  = op_bus.op_rd_addr;
               en_s             = en_mask_s;
               g_s              = '0;
               rdata_s          = '0;
               wb_s             = '0;
               if (|en_mask_s) begin
                  state_s = ACQ;
               end else begin
                  state_s = EXEC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACQ: begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               if (en_r[p] && port_bus.port_grant[p] && !g_r[p]) begin
                  g_s[p] = 1'b1;
               end else begin
                  g_s[p] = g_r[p];
               end
            end
            // Read data is captured only on the cycle the grant first lands.
            if (en_r[PORT_RS] && port_bus.port_grant[PORT_RS] && !g_r[PORT_RS]) begin
               rdata_s[PORT_RS] = port_bus.port_rdata[PORT_RS];
            end else begin
               rdata_s[PORT_RS] = rdata_r[PORT_RS];
            end
            if (en_r[PORT_RT] && port_bus.port_grant[PORT_RT] && !g_r[PORT_RT]) begin
               rdata_s[PORT_RT] = port_bus.port_rdata[PORT_RT];
            end else begin
               rdata_s[PORT_RT] = rdata_r[PORT_RT];
            end
            if ((g_s & en_r) == en_r) begin
               state_s = EXEC;
            end else begin
               state_s = ACQ;
            end
         end
         EXEC: begin
            if (op_bus.ex_done) begin
               wb_s    = op_bus.ex_wdata;
               state_s = REL;
            end else begin
               state_s = EXEC;
            end
         end
         REL: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output values as they must appear while in the next state.
   always_comb begin
      held_s      = (state_s != IDLE);
      op_ready_s  = (state_s == IDLE);
      src_valid_s = (state_s == EXEC);
      op_done_s   = (state_s == REL);
      src_rs_s    = (state_s == EXEC) ? rdata_s[PORT_RS] : '0;
      src_rt_s    = (state_s == EXEC) ? rdata_s[PORT_RT] : '0;
      paddr_s     = '0;
      pid_s       = '0;
      rel_s       = '0;
      req_rd_s    = '0;
      req_wr_s    = '0;
      pwdata_s    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (held_s && en_s[p]) begin
            paddr_s[p] = addr_s[p];
            pid_s[p]   = id_s;
            rel_s[p]   = (state_s == REL);
         end else begin
            paddr_s[p] = '0;
            pid_s[p]   = '0;
            rel_s[p]   = 1'b0;
         end
      end
      req_rd_s[PORT_RS] = held_s && en_s[PORT_RS];
      req_rd_s[PORT_RT] = held_s && en_s[PORT_RT];
      req_wr_s[PORT_RD] = held_s && en_s[PORT_RD];
      if ((state_s == REL) && en_s[PORT_RD]) begin
         pwdata_s[PORT_RD] = wb_s;
      end else begin
         pwdata_s[PORT_RD] = '0;
      end
   end

   // Saturating count of cycles spent waiting for grants.
   always_comb begin
      if ((state_r == ACQ) && (cnt_r != {CNT_WIDTH{1'b1}})) begin
         cnt_s = cnt_r + CNT_WIDTH'(1);
      end else begin
         cnt_s = cnt_r;
      end
   end

   // State and operation latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         id_r    <= '0;
         addr_r  <= '0;
         en_r    <= '0;
         g_r     <= '0;
         rdata_r <= '0;
         wb_r    <= '0;
      end else begin
         state_r <= state_s;
         id_r    <= id_s;
         addr_r  <= addr_s;
         en_r    <= en_s;
         g_r     <= g_s;
         rdata_r <= rdata_s;
         wb_r    <= wb_s;
      end
   end

   // Registered outputs, all zero while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_ready_r  <= 1'b0;
         src_valid_r <= 1'b0;
         src_rs_r    <= '0;
         src_rt_r    <= '0;
         op_done_r   <= 1'b0;
         paddr_r     <= '0;
         req_rd_r    <= '0;
         req_wr_r    <= '0;
         pid_r       <= '0;
         rel_r       <= '0;
         pwdata_r    <= '0;
         cnt_r       <= '0;
      end else begin
         op_ready_r  <= op_ready_s;
         src_valid_r <= src_valid_s;
         src_rs_r    <= src_rs_s;
         src_rt_r    <= src_rt_s;
         op_done_r   <= op_done_s;
         paddr_r     <= paddr_s;
         req_rd_r    <= req_rd_s;
         req_wr_r    <= req_wr_s;
         pid_r       <= pid_s;
         rel_r       <= rel_s;
         pwdata_r    <= pwdata_s;
         cnt_r       <= cnt_s;
      end
   end

   assign op_bus.op_ready         = op_ready_r;
   assign op_bus.src_valid        = src_valid_r;
   assign op_bus.src_rs_data      = src_rs_r;
   assign op_bus.src_rt_data      = src_rt_r;
   assign op_bus.op_done          = op_done_r;
   assign port_bus.port_addr      = paddr_r;
   assign port_bus.port_req_read  = req_rd_r;
   assign port_bus.port_req_write = req_wr_r;
   assign port_bus.port_issue_id  = pid_r;
   assign port_bus.port_release   = rel_r;
   assign port_bus.port_wdata     = pwdata_r;
   assign acq_stall_cnt           = cnt_r;

endmodule

// File: doc/sic_reg_client.md
Name: sic_reg_client

Overview:
- Per-instruction requester for the locking register file. One instance sits in each SIC and owns 3 consecutive global ports (rs read, rt read, rd write).
- Accepts one decoded operation and raises read/write requests tagged with the issue ID. Holds the requests until every enabled port is granted, then hands operands to execute.
- Takes the writeback value from execute, then pulses release on all held ports, which commits the write and frees the locks.

Parameters:
- NUM_PHY_REGS, 32, number of physical registers; address width AW = $clog2(NUM_PHY_REGS).
- ID_WIDTH, 8, issue ID width.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation offered
- op_ready  out  1  client idle, can accept an operation
- op_issue_id  in  ID_WIDTH  issue ID for all 3 ports
- op_rs_en / op_rt_en / op_rd_en  in  1 each  port enables
- op_rs_addr / op_rt_addr / op_rd_addr  in  AW each  register addresses
- src_valid  out  1  operands valid (EXEC state)
- src_rs_data / src_rt_data  out  32 each  latched read data
- ex_done  in  1  execute finished; sampled only while src_valid=1
- ex_wdata  in  32  writeback value, sampled with ex_done
- op_done  out  1  one-cycle pulse in the REL cycle
- port_addr  out  [3] x AW  port index 0=rs, 1=rt, 2=rd
- port_req_read  out  [3] x 1
- port_req_write  out  [3] x 1
- port_issue_id  out  [3] x ID_WIDTH
- port_release  out  [3] x 1
- port_wdata  out  [3] x 32  only index 2 is meaningful; 0 and 1 drive 0
- port_rdata  in  [3] x 32  valid when port_grant && port_req_read
- port_grant  in  [3] x 1
- acq_stall_cnt  out  CNT_WIDTH  cumulative ACQ cycles, saturating

Behaviour:
- State machine IDLE, ACQ, EXEC, REL.
- Reset value of every output is 0, including the stall counter. State resets to IDLE.
- Reset mid-operation: return to IDLE immediately; no release is issued (the register file shares rst_n).
- IDLE: op_ready=1. A handshake (op_valid && op_ready) latches the ID, addresses and enables, and clears the grant flags g[2:0] and data latches.
  - Any enabled port whose address is >= NUM_PHY_REGS is treated as disabled; its read data is 0.
  - Next state is ACQ, or EXEC directly if no port is enabled after masking.
- ACQ:
  - Port 0 drives req_read=en_rs; port 1 drives req_read=en_rt; port 2 drives req_write=en_rd.
  - port_addr and port_issue_id are driven from the latches.
  - Each cycle, for each enabled port with port_grant=1 and g=0: set g, and latch port_rdata for ports 0 and 1.
  - g is sticky. Requests stay asserted after grant.
  - Move to EXEC when every enabled port has g=1, counting the latch of the current cycle.
  - acq_stall_cnt increments by 1 each ACQ cycle and saturates at all-ones.
  - Minimum ACQ length is 1 cycle, for a same-cycle grant.
- EXEC:
  - Requests stay asserted on held ports.
  - src_valid=1 and src_*_data drive the latched values.
  - ex_done=1 latches ex_wdata and moves to REL. ex_done outside EXEC is ignored.
- REL, exactly 1 cycle:
  - port_release=1 on enabled ports; requests stay asserted with stable addr and ID.
  - port_wdata[2] = latched wb value; write commits here.
  - op_done=1. Next state is IDLE, where all requests and releases drop to 0.
- op_ready is 0 outside IDLE; there is no back-to-back acceptance. Minimum op latency from accept to op_done is 3 cycles (ACQ 1, EXEC 1, REL 1).
- rs and rt may share an address: both ports request read independently.
- Addresses, issue ID and wdata are stable from ACQ through REL.
- Outputs port_* that are not driven by an enable are 0.

Decomposition:
- Package sic_pkg: state enum {IDLE, ACQ, EXEC, REL}, port index constants PORT_RS=0, PORT_RT=1, PORT_RD=2, and the number of ports per SIC (3).
- No sub-module is needed. The saturating counter is inline.

Test Plan:
- Read-only op: rs=5 (holds 0x11), rt=6 (holds 0x22), grants in the first ACQ cycle -> src_valid 2 cycles after accept with 0x11/0x22; ex_done -> release[0] and release[1] pulse once, release[2]=0, op_done, acq_stall_cnt=1.
- Write op: rd=7, ex_wdata=0xDEADBEEF -> in REL, port_release[2]=1 and port_wdata[2]=0xDEADBEEF; a later read of r7 by another port returns 0xDEADBEEF.
- Delayed grant: rt grant withheld 4 cycles while rs is granted at once -> ACQ lasts 5 cycles, rs data latched at the first cycle, req_read[0] stays high throughout, acq_stall_cnt=5.
- No enables: all en=0 -> accept goes straight to EXEC; no req or release is ever asserted; op_done follows ex_done.
- Reset during EXEC: rst_n low -> all outputs 0 asynchronously and op_ready=1 after deassertion.
- Saturation: CNT_WIDTH=4 with 20 stall cycles -> acq_stall_cnt holds 15.
